// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the device clock, frames
// 11-bit PS/2 packets, checks odd parity and stop bit, and decodes a handful of
// game keys (arrows via the E0 prefix, space/enter as start) into level outputs.
module ps2_key_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic       start
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [13:0] TIMEOUT_MAX = 14'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [1:0]     clkSync_q;
    logic [1:0]     dataSync_q;
    logic           filtClk_q;
    logic           filtClk_d;
    logic           filtClkPrev_q;
    logic [FCW-1:0] filtCnt_q;
    logic [FCW-1:0] filtCnt_d;
    logic           fallEdge;
    logic           dataBit;

    state_t         state_q;
    logic [2:0]     bitCnt_q;
    logic [7:0]     shift_q;
    logic           parity_q;
    logic [13:0]    timeout_q;
    logic [7:0]     scanCode_q;
    logic           codeValid_q;
    logic           frameErr_q;
    logic           extFlag_q;
    logic           brkFlag_q;
    logic           left_q;
    logic           right_q;
    logic           up_q;
    logic           down_q;
    logic           space_q;
    logic           enter_q;

    // Two-flop synchronizers; idle level of the PS/2 lines is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk};
            dataSync_q <= {dataSync_q[0], ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filtClk_d = filtClk_q;
        filtCnt_d = '0;
        if (clkSync_q[1] != filtClk_q) begin
            if (filtCnt_q == FILT_MAX) begin
                filtClk_d = ~filtClk_q;
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    // Register the filtered clock and its previous value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            filtClk_q     <= 1'b1;
            filtClkPrev_q <= 1'b1;
            filtCnt_q     <= '0;
        end else begin
            filtClk_q     <= filtClk_d;
            filtClkPrev_q <= filtClk_q;
            filtCnt_q     <= filtCnt_d;
        end
    end

    assign fallEdge = filtClkPrev_q & ~filtClk_q;
    assign dataBit  = dataSync_q[1];

    // Frame receiver, inactivity timeout and key decoder with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            timeout_q   <= '0;
            scanCode_q  <= '0;
            codeValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            extFlag_q   <= 1'b0;
            brkFlag_q   <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            space_q     <= 1'b0;
            enter_q     <= 1'b0;
        end else begin
            codeValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            if (state_q == IDLE) begin
                timeout_q <= '0;
                if (fallEdge) begin
                    if (!dataBit) begin
                        state_q  <= DATA;
                        bitCnt_q <= '0;
                    end else begin
                        frameErr_q <= 1'b1;
                        extFlag_q  <= 1'b0;
                        brkFlag_q  <= 1'b0;
                    end
                end
            end else if (fallEdge) begin
                timeout_q <= '0;
                case (state_q)
                    DATA: begin
                        shift_q  <= {dataBit, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= dataBit;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (dataBit && (^{shift_q, parity_q})) begin
                            scanCode_q  <= shift_q;
                            codeValid_q <= 1'b1;
                            if (shift_q == 8'hE0) begin
                                extFlag_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brkFlag_q <= 1'b1;
                            end else begin
                                if (extFlag_q) begin
                                    case (shift_q)
                                        8'h6B:   left_q  <= ~brkFlag_q;
                                        8'h74:   right_q <= ~brkFlag_q;
                                        8'h75:   up_q    <= ~brkFlag_q;
                                        8'h72:   down_q  <= ~brkFlag_q;
                                        default: ;
                                    endcase
                                end else begin
                                    case (shift_q)
                                        8'h29:   space_q <= ~brkFlag_q;
                                        8'h5A:   enter_q <= ~brkFlag_q;
                                        default: ;
                                    endcase
                                end
                                extFlag_q <= 1'b0;
                                brkFlag_q <= 1'b0;
                            end
                        end else begin
                            frameErr_q <= 1'b1;
                            extFlag_q  <= 1'b0;
                            brkFlag_q  <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (timeout_q == TIMEOUT_MAX) begin
                state_q   <= IDLE;
                bitCnt_q  <= '0;
                shift_q   <= '0;
                timeout_q <= '0;
                extFlag_q <= 1'b0;
                brkFlag_q <= 1'b0;
            end else begin
                timeout_q <= timeout_q + 14'd1;
            end
        end
    end

    assign scan_code  = scanCode_q;
    assign code_valid = codeValid_q;
    assign frame_err  = frameErr_q;
    assign left       = left_q;
    assign right      = right_q;
    assign up         = up_q;
    assign down       = down_q;
    assign start      = space_q | enter_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx. PS/2 timing is scaled down (bit period of
// 120 clk cycles, timeout of 180 cycles) keeping the timeout/bit-period ratio of
// the real device, so the whole run stays short.
module tb_ps2_key_rx;

    localparam int HALF    = 60;
    localparam int QUARTER = 30;
    localparam int TIMEOUT = 180;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       start;

    typedef struct {
        logic [7:0] code;
        logic [4:0] keys;
    } expect_t;

    expect_t sbQueue[$];
    int      total = 0;
    int      bad = 0;
    int      validCount = 0;
    int      frameErrCount = 0;
    int      v0;
    int      f0;

    ps2_key_rx #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .left      (left),
        .right     (right),
        .up        (up),
        .down      (down),
        .start     (start)
    );

    // 100 MHz system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives frame bits firstBit..lastBit of one PS/2 packet, optionally with a
    // short low glitch in each clock-high phase; queues the expected result.
    task automatic applyStimulus(input logic [7:0] code, input bit badParity,
                                 input int firstBit, input int lastBit,
                                 input bit glitch, input bit expectValid,
                                 input logic [4:0] expKeys);
        logic [10:0] frame;
        expect_t     e;
        frame = {1'b1, (~^code) ^ badParity, code, 1'b0};
        if (expectValid) begin
            e.code = code;
            e.keys = expKeys;
            sbQueue.push_back(e);
        end
        for (int i = firstBit; i <= lastBit; i++) begin
            ps2_data = frame[i];
            waitCycles(10);
            if (glitch) begin
                ps2_clk = 1'b0;
                waitCycles(5);
                ps2_clk = 1'b1;
            end else begin
                waitCycles(5);
            end
            waitCycles(QUARTER - 15);
            ps2_clk = 1'b0;
            waitCycles(HALF);
            ps2_clk = 1'b1;
            waitCycles(QUARTER);
        end
        ps2_data = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] code, input logic [4:0] expKeys);
        applyStimulus(code, 1'b0, 0, 10, 1'b0, 1'b1, expKeys);
    endtask

    task automatic sendGlitched(input logic [7:0] code, input logic [4:0] expKeys);
        applyStimulus(code, 1'b0, 0, 10, 1'b1, 1'b1, expKeys);
    endtask

    // Scoreboard side: every code_valid pops one expected byte and key state.
    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid || frame_err) begin
                checkOutput("exclusivePulse", 32'(code_valid & frame_err), 32'd0);
            end
            if (frame_err) begin
                frameErrCount++;
            end
            if (code_valid) begin
                validCount++;
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedValid", 32'(code_valid), 32'd0);
                end else begin
                    expect_t e;
                    e = sbQueue.pop_front();
                    checkOutput("scanCode", 32'(scan_code), 32'(e.code));
                    checkOutput("keys", 32'({left, right, up, down, start}), 32'(e.keys));
                end
            end
        end
    end

    // Key vector order in expectations: {left, right, up, down, start}.
    initial begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst      = 1'b1;
        waitCycles(5);
        checkOutput("rstScanCode", 32'(scan_code), 32'h00);
        checkOutput("rstCodeValid", 32'(code_valid), 32'd0);
        checkOutput("rstFrameErr", 32'(frame_err), 32'd0);
        checkOutput("rstKeys", 32'({left, right, up, down, start}), 32'd0);
        rst = 1'b0;
        waitCycles(5);

        // Single plain frame.
        v0 = validCount;
        f0 = frameErrCount;
        sendByte(8'h1C, 5'b00000);
        checkOutput("t1ValidCount", 32'(validCount - v0), 32'd1);
        checkOutput("t1FrameErr", 32'(frameErrCount - f0), 32'd0);
        checkOutput("t1ScanCode", 32'(scan_code), 32'h1C);

        // Extended make and break of the up arrow.
        v0 = validCount;
        f0 = frameErrCount;
        sendByte(8'hE0, 5'b00000);
        sendByte(8'h75, 5'b00100);
        sendByte(8'hE0, 5'b00100);
        sendByte(8'hF0, 5'b00100);
        sendByte(8'h75, 5'b00000);
        checkOutput("t2ValidCount", 32'(validCount - v0), 32'd5);
        checkOutput("t2FrameErr", 32'(frameErrCount - f0), 32'd0);

        // Parity error, then a good space press, then space/enter overlap.
        f0 = frameErrCount;
        applyStimulus(8'h29, 1'b1, 0, 10, 1'b0, 1'b0, 5'b00000);
        checkOutput("t3FrameErr", 32'(frameErrCount - f0), 32'd1);
        checkOutput("t3ScanKept", 32'(scan_code), 32'h75);
        checkOutput("t3StartLow", 32'(start), 32'd0);
        sendByte(8'h29, 5'b00001);
        checkOutput("t3StartHigh", 32'(start), 32'd1);
        sendByte(8'h5A, 5'b00001);
        sendByte(8'hF0, 5'b00001);
        sendByte(8'h29, 5'b00001);
        sendByte(8'hF0, 5'b00001);
        sendByte(8'h5A, 5'b00000);

        // Partial frame abandoned by the timeout, then a clean enter press.
        v0 = validCount;
        f0 = frameErrCount;
        applyStimulus(8'h5A, 1'b0, 0, 3, 1'b0, 1'b0, 5'b00000);
        waitCycles(TIMEOUT + 120);
        sendByte(8'h5A, 5'b00001);
        checkOutput("t4FrameErr", 32'(frameErrCount - f0), 32'd0);
        checkOutput("t4ValidCount", 32'(validCount - v0), 32'd1);
        checkOutput("t4ScanCode", 32'(scan_code), 32'h5A);
        checkOutput("t4Start", 32'(start), 32'd1);
        sendByte(8'hF0, 5'b00001);
        sendByte(8'h5A, 5'b00000);

        // Clock glitches while idle and inside frames.
        f0 = frameErrCount;
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            waitCycles(5);
            ps2_clk = 1'b1;
            waitCycles(30);
        end
        checkOutput("t5IdleGlitch", 32'(frameErrCount - f0), 32'd0);
        sendGlitched(8'hE0, 5'b00000);
        sendGlitched(8'h6B, 5'b10000);
        checkOutput("t5Left", 32'(left), 32'd1);
        sendGlitched(8'hE0, 5'b10000);
        sendGlitched(8'hF0, 5'b10000);
        sendGlitched(8'h6B, 5'b00000);
        checkOutput("t5FrameErr", 32'(frameErrCount - f0), 32'd0);

        // Reset in the middle of a frame.
        sendByte(8'hE0, 5'b00000);
        sendByte(8'h74, 5'b01000);
        v0 = validCount;
        applyStimulus(8'h74, 1'b0, 0, 5, 1'b0, 1'b0, 5'b00000);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("t6RstScan", 32'(scan_code), 32'h00);
        checkOutput("t6RstKeys", 32'({left, right, up, down, start}), 32'd0);
        checkOutput("t6RstValid", 32'(code_valid), 32'd0);
        checkOutput("t6RstErr", 32'(frame_err), 32'd0);
        applyStimulus(8'h74, 1'b0, 6, 10, 1'b0, 1'b0, 5'b00000);
        waitCycles(TIMEOUT + 120);
        checkOutput("t6NoValid", 32'(validCount - v0), 32'd0);
        sendByte(8'h74, 5'b00000);
        checkOutput("t6ValidCount", 32'(validCount - v0), 32'd1);
        checkOutput("t6ScanCode", 32'(scan_code), 32'h74);

        waitCycles(20);
        checkOutput("queueEmpty", 32'(sbQueue.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required before the filtered clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 12000: clk cycles without a filtered falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 scan_code  output  8  last correctly received byte.
REQ-008 code_valid  output  1  one-cycle pulse when scan_code is updated.
REQ-009 frame_err  output  1  one-cycle pulse on a start, parity or stop error.
REQ-010 left, right, up, down, start  output  1 each  held high while the matching key is pressed.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 The filtered clock SHALL start at 1 and toggle only after FILTER_LEN consecutive samples that differ from its current value.
REQ-013 A falling edge SHALL be a 1->0 transition of the filtered clock; ps2_data SHALL be sampled (synchronized value) on that cycle only.
REQ-014 The FSM states SHALL be IDLE, DATA, PARITY, STOP; reset state is IDLE.
REQ-015 IDLE: a falling edge with data 0 SHALL go to DATA with bit count 0; with data 1 it SHALL pulse frame_err and remain in IDLE.
REQ-016 DATA: each edge SHALL shift data in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-017 PARITY: the sampled bit SHALL be recorded; odd parity over the 8 data bits plus parity bit is required; go to STOP.
REQ-018 STOP: on the edge, if stop=1 and parity is correct, scan_code SHALL load the byte and code_valid SHALL pulse on the next cycle; otherwise frame_err SHALL pulse and scan_code is unchanged; both cases return to IDLE.
REQ-019 code_valid and frame_err SHALL never be high in the same cycle.
REQ-020 In any non-IDLE state, TIMEOUT_CYCLES cycles without an edge SHALL return the FSM to IDLE, discard the partial byte, clear the prefix flags, and not pulse frame_err; the counter resets on every edge and is 14 bits wide.
REQ-021 Decoder: a valid byte 0xE0 SHALL set ext_flag, and a valid 0xF0 SHALL set brk_flag; neither changes key outputs.
REQ-022 Any other valid byte SHALL be decoded with ext_flag and then clear both flags.
REQ-023 Key mapping: ext+0x6B sets left, ext+0x74 sets right, ext+0x75 sets up, and ext+0x72 sets down.
REQ-024 Key mapping: non-ext 0x29 (space) or 0x5A (enter) sets start.
REQ-025 Key level rule: brk_flag=0 sets the key level to 1, and brk_flag=1 clears it to 0.
REQ-026 Key outputs SHALL update in the same cycle as code_valid; unmapped codes only clear the flags.
REQ-027 The start output SHALL remain high while either space or enter is held, tracked independently.
REQ-028 A frame_err SHALL clear ext_flag and brk_flag.

Reset
REQ-029 Reset SHALL force FSM=IDLE, bit count=0, timeout counter=0, filtered clock=1, and synchronizers=1.
REQ-030 Reset SHALL force scan_code=0x00, code_valid=0, frame_err=0, all key outputs=0, and both flags=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the first output pulse after reset requires a complete new frame.

Verification
REQ-032 Send frame 0x1C with parity 0 at 80 us bit period -> one code_valid pulse, scan_code=0x1C, frame_err never high.
REQ-033 Send E0 75, then E0 F0 75 -> up rises with the 2nd code_valid, falls with the 5th, other keys stay 0.
REQ-034 Send 0x29 with wrong parity -> frame_err one pulse, scan_code unchanged, start stays 0; then a correct 0x29 -> start=1.
REQ-035 Send 4 bits, then idle 130 us, then a full 0x5A frame -> no frame_err, one code_valid, scan_code=0x5A, start=1.
REQ-036 Inject 50 ns low glitches on ps2_clk during idle and mid-frame -> no extra bits shifted, received bytes correct.
REQ-037 Assert rst for 1 cycle after bit 5 of a frame -> all outputs at reset values, the remainder of that frame yields no code_valid, and the next frame decodes correctly.
